ex_cluster: RTL and testbench

EX_CLUSTER -- requirements
Module: ex_cluster

---
 rtl/ex_cluster.sv | 146 ++++++++++++++
 tb/tb_ex_cluster.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_cluster.sv
// Execution cluster: NUM_ALU single-cycle ALU lanes followed by NUM_MULT pipelined multiplier lanes.
// Optional feature macro: EX_STALL_CNT_EN adds per-lane saturating stall counters on port stall_cnt.
module ex_cluster #(
    parameter int NUM_ALU     = 2,
    parameter int NUM_MULT    = 2,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 5,
    parameter int MULT_STAGES = 4,
    localparam int NL         = NUM_ALU + NUM_MULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic [NL-1:0]       in_valid,
    output logic [NL-1:0]       in_ready,
    input  logic [3*NL-1:0]     in_op,
    input  logic [XLEN*NL-1:0]  in_a,
    input  logic [XLEN*NL-1:0]  in_b,
    input  logic [TAG_W*NL-1:0] in_tag,
    output logic [NL-1:0]       out_valid,
    output logic [XLEN*NL-1:0]  out_data,
    output logic [TAG_W*NL-1:0] out_tag,
    input  logic [NL-1:0]       ack
`ifdef EX_STALL_CNT_EN
    ,
    output logic [32*NL-1:0]    stall_cnt
`endif
);

    localparam int SHW = $clog2(XLEN);

    for (genvar l = 0; l < NUM_ALU; l++) begin : g_alu
        logic [2:0]       op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  res;
        logic             rdy;
        logic             accept;
        logic             v_q;
        logic [XLEN-1:0]  d_q;
        logic [TAG_W-1:0] t_q;

        assign op     = in_op[3*l +: 3];
        assign a      = in_a[XLEN*l +: XLEN];
        assign b      = in_b[XLEN*l +: XLEN];
        assign rdy    = !v_q || ack[l];
        assign accept = in_valid[l] && rdy && !squash;

        always_comb begin
            res = '0;
            case (op)
                3'd0:    res = a + b;
                3'd1:    res = a - b;
                3'd2:    res = a & b;
                3'd3:    res = a | b;
                3'd4:    res = a ^ b;
                3'd5:    res = XLEN'($signed(a) < $signed(b));
                3'd6:    res = XLEN'(a < b);
                3'd7:    res = a << b[SHW-1:0];
                default: res = '0;
            endcase
        end

        // Acceptance has priority over ack so a same-cycle ack+issue replaces without a bubble.
        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= 1'b0;
                d_q <= '0;
                t_q <= '0;
            end else if (squash) begin
                v_q <= 1'b0;
            end else if (accept) begin
                v_q <= 1'b1;
                d_q <= res;
                t_q <= in_tag[TAG_W*l +: TAG_W];
            end else if (ack[l]) begin
                v_q <= 1'b0;
            end
        end

        assign in_ready[l]                 = rdy;
        assign out_valid[l]                = v_q;
        assign out_data[XLEN*l +: XLEN]    = d_q;
        assign out_tag[TAG_W*l +: TAG_W]   = t_q;
    end

    for (genvar l = NUM_ALU; l < NL; l++) begin : g_mul
        logic [2:0]             unused_op;
        logic [XLEN-1:0]        prod;
        logic                   adv;
        logic                   accept;
        logic [MULT_STAGES-1:0] v_q;
        logic [XLEN-1:0]        d_q [MULT_STAGES];
        logic [TAG_W-1:0]       t_q [MULT_STAGES];

        assign unused_op = in_op[3*l +: 3];
        assign prod      = in_a[XLEN*l +: XLEN] * in_b[XLEN*l +: XLEN];
        assign adv       = !v_q[MULT_STAGES-1] || ack[l];
        assign accept    = in_valid[l] && adv && !squash;

        // A stall freezes the whole pipe; empty stages are not collapsed.
        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= '0;
                for (int s = 0; s < MULT_STAGES; s++) begin
                    d_q[s] <= '0;
                    t_q[s] <= '0;
                end
            end else if (squash) begin
                v_q <= '0;
            end else if (adv) begin
                v_q[0] <= accept;
                d_q[0] <= prod;
                t_q[0] <= in_tag[TAG_W*l +: TAG_W];
                for (int s = 1; s < MULT_STAGES; s++) begin
                    v_q[s] <= v_q[s-1];
                    d_q[s] <= d_q[s-1];
                    t_q[s] <= t_q[s-1];
                end
            end
        end

        assign in_ready[l]               = adv;
        assign out_valid[l]              = v_q[MULT_STAGES-1];
        assign out_data[XLEN*l +: XLEN]  = d_q[MULT_STAGES-1];
        assign out_tag[TAG_W*l +: TAG_W] = t_q[MULT_STAGES-1];
    end

`ifdef EX_STALL_CNT_EN
    for (genvar l = 0; l < NL; l++) begin : g_stall
        logic [31:0] cnt_q;

        // Squash deliberately does not clear the counter; only reset does.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (out_valid[l] && !ack[l] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign stall_cnt[32*l +: 32] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_ex_cluster.sv
// Self-checking bench for ex_cluster: queue-based lane model, directed literal checks, then random traffic.
module tb_ex_cluster;
    localparam int NUM_ALU     = 2;
    localparam int NUM_MULT    = 2;
    localparam int XLEN        = 32;
    localparam int TAG_W       = 5;
    localparam int MULT_STAGES = 4;
    localparam int NL          = NUM_ALU + NUM_MULT;

    logic                clock = 1'b0;
    logic                reset;
    logic                squash;
    logic [NL-1:0]       in_valid;
    logic [NL-1:0]       in_ready;
    logic [3*NL-1:0]     in_op;
    logic [XLEN*NL-1:0]  in_a;
    logic [XLEN*NL-1:0]  in_b;
    logic [TAG_W*NL-1:0] in_tag;
    logic [NL-1:0]       out_valid;
    logic [XLEN*NL-1:0]  out_data;
    logic [TAG_W*NL-1:0] out_tag;
    logic [NL-1:0]       ack;
`ifdef EX_STALL_CNT_EN
    logic [32*NL-1:0]    stall_cnt;
`endif

    ex_cluster #(
        .NUM_ALU(NUM_ALU), .NUM_MULT(NUM_MULT), .XLEN(XLEN),
        .TAG_W(TAG_W), .MULT_STAGES(MULT_STAGES)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
        .ack(ack)
`ifdef EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    typedef struct {
        logic [XLEN-1:0]  d;
        logic [TAG_W-1:0] t;
        int               age;
    } ent_t;

    ent_t        q [NL][$];
    logic [31:0] mcnt [NL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat(int l);
        return (l < NUM_ALU) ? 1 : MULT_STAGES;
    endfunction

    // A result is visible once it has moved through all of its lane's stages.
    function automatic bit head_ready(int l);
        return (q[l].size() > 0) && (q[l][0].age == lat(l));
    endfunction

    function automatic logic [XLEN-1:0] exp_res(int l, logic [2:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [63:0] full;
        if (l >= NUM_ALU) begin
            full = 64'(a) * 64'(b);
            return full[XLEN-1:0];
        end
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return a << b[4:0];
        endcase
    endfunction

    always @(posedge clock) begin
        for (int l = 0; l < NL; l++) begin
            if (reset) begin
                q[l].delete();
                mcnt[l] = 0;
            end else begin
                if (head_ready(l) && !ack[l] && mcnt[l] != 32'hFFFF_FFFF) mcnt[l] = mcnt[l] + 1;
                if (squash) begin
                    q[l].delete();
                end else if (!head_ready(l) || ack[l]) begin
                    ent_t e;
                    if (head_ready(l)) void'(q[l].pop_front());
                    for (int i = 0; i < q[l].size(); i++) begin
                        e = q[l][i];
                        e.age++;
                        q[l][i] = e;
                    end
                    if (in_valid[l]) begin
                        e.d   = exp_res(l, in_op[3*l +: 3], in_a[XLEN*l +: XLEN], in_b[XLEN*l +: XLEN]);
                        e.t   = in_tag[TAG_W*l +: TAG_W];
                        e.age = 1;
                        q[l].push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("out_valid[%0d]", l), 64'(out_valid[l]), 64'(head_ready(l)));
                chk($sformatf("in_ready[%0d]", l), 64'(in_ready[l]), 64'(!head_ready(l) || ack[l]));
                if (head_ready(l)) begin
                    chk($sformatf("out_data[%0d]", l), 64'(out_data[XLEN*l +: XLEN]), 64'(q[l][0].d));
                    chk($sformatf("out_tag[%0d]", l), 64'(out_tag[TAG_W*l +: TAG_W]), 64'(q[l][0].t));
                end
`ifdef EX_STALL_CNT_EN
                chk($sformatf("stall_cnt[%0d]", l), 64'(stall_cnt[32*l +: 32]), 64'(mcnt[l]));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_in();
        squash   = 1'b0;
        in_valid = '0;
        in_op    = '0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
    endtask

    task automatic issue(int l, logic [2:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [TAG_W-1:0] t);
        in_valid[l]              = 1'b1;
        in_op[3*l +: 3]          = op;
        in_a[XLEN*l +: XLEN]     = a;
        in_b[XLEN*l +: XLEN]     = b;
        in_tag[TAG_W*l +: TAG_W] = t;
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        ack = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ack   = '0;
        clear_in();
        step();
        step();
        checking = 1;
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset out_data", 64'(out_data[63:0]), 64'h0);
        chk("reset out_tag", 64'(out_tag), 64'h0);
        reset = 1'b0;
        step();
        chk("in_ready after reset", 64'(in_ready), 64'hF);

        // ADD wraps to zero and carries the tag.
        issue(0, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
        step();
        clear_in();
        chk("add out_valid", 64'(out_valid[0]), 64'h1);
        chk("add out_data", 64'(out_data[31:0]), 64'h0);
        chk("add out_tag", 64'(out_tag[4:0]), 64'h3);

        ack = '1;
        issue(0, 3'd5, 32'h8000_0000, 32'd1, 5'd4);
        issue(1, 3'd6, 32'h8000_0000, 32'd1, 5'd5);
        step();
        clear_in();
        chk("slt", 64'(out_data[31:0]), 64'h1);
        chk("sltu", 64'(out_data[63:32]), 64'h0);
        issue(0, 3'd7, 32'd1, 32'h21, 5'd6);
        issue(1, 3'd1, 32'd5, 32'd7, 5'd7);
        step();
        clear_in();
        chk("sll", 64'(out_data[31:0]), 64'h2);
        chk("sub", 64'(out_data[63:32]), 64'hFFFF_FFFE);

        // Multiplier latency, then back-to-back results in order.
        issue(2, 3'd0, 32'd7, 32'd6, 5'd9);
        step();
        clear_in();
        step();
        step();
        chk("mul not early", 64'(out_valid[2]), 64'h0);
        step();
        chk("mul valid", 64'(out_valid[2]), 64'h1);
        chk("mul data", 64'(out_data[95:64]), 64'd42);
        for (int k = 1; k <= 3; k++) begin
            issue(2, 3'd0, 32'(k), 32'd10, 5'(k));
            step();
        end
        clear_in();
        step();
        chk("b2b first", 64'(out_data[95:64]), 64'd10);
        step();
        chk("b2b second", 64'(out_data[95:64]), 64'd20);
        step();
        chk("b2b third", 64'(out_data[95:64]), 64'd30);
        step();

        // Stall with in_valid held: the pipe fills and in_ready drops.
        ack = '0;
        for (int k = 0; k < 9; k++) begin
            issue(2, 3'd0, 32'(k + 2), 32'd3, 5'(k));
            step();
        end
        chk("stall in_ready", 64'(in_ready[2]), 64'h0);
        chk("stall head", 64'(out_data[95:64]), 64'd6);
        clear_in();
        ack = '1;
        repeat (8) step();
        chk("drained", 64'(out_valid[2]), 64'h0);

        // Squash with held results and in-flight work.
        ack = '0;
        issue(0, 3'd0, 32'd1, 32'd1, 5'd1);
        issue(2, 3'd0, 32'd2, 32'd2, 5'd2);
        step();
        clear_in();
        for (int k = 0; k < 3; k++) begin
            issue(3, 3'd0, 32'(k), 32'd5, 5'(k));
            step();
        end
        clear_in();
        chk("pre-squash held", 64'({out_valid[2], out_valid[0]}), 64'h3);
        squash = 1'b1;
        issue(1, 3'd0, 32'd3, 32'd4, 5'd8);
        step();
        clear_in();
        chk("squash out_valid", 64'(out_valid), 64'h0);
        repeat (6) step();
        chk("no stale result", 64'(out_valid), 64'h0);

`ifdef EX_STALL_CNT_EN
        do_reset();
        issue(0, 3'd0, 32'd1, 32'd2, 5'd1);
        step();
        clear_in();
        step();
        step();
        squash = 1'b1;
        step();
        squash = 1'b0;
        chk("stall_cnt held", 64'(stall_cnt[31:0]), 64'd3);
        step();
        chk("stall_cnt kept", 64'(stall_cnt[31:0]), 64'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("stall_cnt reset", 64'(stall_cnt[31:0]), 64'd0);
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            squash = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < NL; l++) begin
                in_valid[l]              = ($urandom_range(0, 3) != 0);
                in_op[3*l +: 3]          = 3'($urandom_range(0, 7));
                in_a[XLEN*l +: XLEN]     = pick_operand();
                in_b[XLEN*l +: XLEN]     = pick_operand();
                in_tag[TAG_W*l +: TAG_W] = 5'($urandom_range(0, 31));
                ack[l]                   = (c % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                                           : ($urandom_range(0, 3) == 0);
            end
            step();
        end
        clear_in();
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
